// File: rtl/w3op_fetch.sv
// Instruction fetch sequencer for w3op: walks a PC over an inclusive SRAM address
// range, absorbs the SRAM's one-cycle read latency and datapath stalls via a skid buffer.
module w3op_fetch #(
  parameter int                    CODE_WIDTH = 36,
  parameter int                    ADDR_WIDTH = 8,
  parameter logic [CODE_WIDTH-1:0] NOP_CODE   = '0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  output logic                  mem_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [CODE_WIDTH-1:0] mem_rdata,
  input  logic                  stall,
  output logic [CODE_WIDTH-1:0] code,
  output logic                  code_valid,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic [CODE_WIDTH-1:0] out_q, out_d;
  logic                  out_valid_q, out_valid_d;
  logic [CODE_WIDTH-1:0] skid_q, skid_d;
  logic                  skid_valid_q, skid_valid_d;
  logic                  done_q, done_d;

  logic issue;
  logic consume;
  logic last;

  // With the skid buffer full no read can be in flight, so a consume never has to
  // place skid data and returning data in the same edge.
  assign issue   = (state_q == S_RUN) && !stall && !skid_valid_q && (remaining_q != '0);
  assign consume = out_valid_q && !stall;
  assign last    = consume && (state_q != S_IDLE) && (remaining_q == '0)
                   && !inflight_q && !skid_valid_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d      = state_q;
    pc_d         = pc_q;
    remaining_d  = remaining_q;
    inflight_d   = issue;
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    done_d       = 1'b0;

    if (issue) begin
      pc_d        = pc_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end

    if (consume) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        skid_valid_d = 1'b0;
      end else if (inflight_q) begin
        out_d = mem_rdata;
      end else begin
        out_d       = NOP_CODE;
        out_valid_d = 1'b0;
      end
    end else if (inflight_q) begin
      if (!out_valid_q) begin
        out_d       = mem_rdata;
        out_valid_d = 1'b1;
      end else begin
        skid_d       = mem_rdata;
        skid_valid_d = 1'b1;
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d        = start_addr;
          remaining_d = {1'b0, ADDR_WIDTH'(end_addr - start_addr)} + 1'b1;
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        if (remaining_d == '0) state_d = S_DRAIN;
      end
      S_DRAIN: ;
      default: state_d = S_IDLE;
    endcase

    if (last) begin
      state_d = S_IDLE;
      done_d  = 1'b1;
    end

    // Abort wins over start and completion; data still returning is dropped.
    if (abort) begin
      state_d      = S_IDLE;
      remaining_d  = '0;
      inflight_d   = 1'b0;
      out_d        = NOP_CODE;
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
      done_d       = 1'b0;
    end
  end

  // NOTE: the skid data register is reset too, so the whole datapath is known after reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q      <= S_IDLE;
      pc_q         <= '0;
      remaining_q  <= '0;
      inflight_q   <= 1'b0;
      out_q        <= NOP_CODE;
      out_valid_q  <= 1'b0;
      skid_q       <= NOP_CODE;
      skid_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      remaining_q  <= remaining_d;
      inflight_q   <= inflight_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      done_q       <= done_d;
    end
  end

  assign mem_en     = issue;
  assign mem_addr   = pc_q;
  assign code       = out_q;
  assign code_valid = out_valid_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: doc/w3op_fetch.md
# w3op_fetch

Instruction fetch sequencer for the w3op datapath. It walks a program counter over an inclusive address range of the 36-bit instruction SRAM and handles the SRAM's one-cycle read latency. It presents one instruction per cycle on the w3op `code` input and absorbs datapath stalls with a one-entry skid buffer. It replaces bench-side instruction feeding with a synthesizable start/abort/done controller.

## Interface
- `CODE_WIDTH`, 36: instruction width.
- `ADDR_WIDTH`, 8: SRAM address width; the PC wraps modulo 2^ADDR_WIDTH.
- `NOP_CODE`, 36'h0: value driven on `code` whenever no valid instruction is presented.
- `clock`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse; loads the range and begins fetching; ignored while `busy`=1.
- `abort`  in  1  synchronous; returns the block to IDLE from any state and discards all instructions; no `done` pulse.
- `start_addr`  in  ADDR_WIDTH  first address, sampled with `start`.
- `end_addr`  in  ADDR_WIDTH  last address (inclusive), sampled with `start`.
- `mem_en`  out  1  SRAM read enable.
- `mem_addr`  out  ADDR_WIDTH  SRAM read address (equals PC).
- `mem_rdata`  in  CODE_WIDTH  SRAM data, valid the cycle after the edge that sampled `mem_en`=1.
- `stall`  in  1  datapath cannot accept; holds `code`/`code_valid`.
- `code`  out  CODE_WIDTH  instruction to w3op; equals NOP_CODE when `code_valid`=0.
- `code_valid`  out  1  `code` holds a real instruction.
- `busy`  out  1  high from the edge after `start` until completion or abort.
- `done`  out  1  one-cycle pulse after the last instruction is consumed.

## Operation
- States:
  - IDLE: `busy`=0. `start`=1 loads PC=start_addr and remaining=((end_addr−start_addr) mod 2^ADDR_WIDTH)+1, width ADDR_WIDTH+1, then goes to RUN.
  - RUN: issues reads until remaining=0, then goes to DRAIN.
  - DRAIN: no reads; waits for the output register and skid buffer to empty.
- `start` and `end_addr`=start_addr gives 1 instruction. end_addr<start_addr wraps through 2^ADDR_WIDTH−1 to 0. The maximum count is 2^ADDR_WIDTH.
- `mem_en` = (state==RUN) & !stall & !skid_valid & (remaining≠0). This is combinational. Each issued read increments the PC (wrapping) and decrements remaining.
- Returning data goes to the output register if it is empty or being consumed this edge. Otherwise it goes to the skid buffer. At most one read is ever in flight, so the skid buffer never overflows.
- Consume: a rising edge with `code_valid`=1 and `stall`=0. On consume, the output register loads from the skid buffer if the skid is full. Otherwise it loads from returning data, or clears to NOP_CODE/`code_valid`=0.
- Completion: the consume edge of the last instruction moves the FSM to IDLE, pulses `done` the next cycle, and drops `busy` the same cycle as `done`.
- `abort` has priority over `start` and completion. It clears valid, skid, in-flight and remaining. Read data returning after an abort is dropped.
- Reset values: `code`=NOP_CODE, `code_valid`=0, `mem_en`=0, `mem_addr`=0, `busy`=0, `done`=0. The FSM is in IDLE and the skid buffer is empty. An asserted reset mid-run discards everything with no `done`.

## Timing
- `start` sampled at edge E0. `mem_en`=1 with addr=start_addr in cycle E0–E1. Data returns in E1–E2. `code_valid`=1 from E2.
- First-instruction latency is 2 cycles. Throughput is 1 instruction/cycle with no stall.
- Consume of the last instruction at edge Ek gives `done`=1 and `busy`=0 in cycle Ek–Ek+1.
- `stall` high at edge t: `code` is unchanged and no read is issued that cycle. A read issued at t−1 lands in the skid buffer.
- After `stall` falls, the skid buffer feeds the next edge. Reads resume the cycle after the skid buffer empties.
- Back-to-back programs: `start` is accepted in the cycle `done` is high.

## Test plan
- SRAM[0..3]=A,B,C,D, start 0→3, no stall: `code`=A,B,C,D at edges E2..E5; `done` in cycle E6–E7; 4 `mem_en` cycles total.
- Same program, `stall` high in cycles E3–E5: `code`=B held across the stall, skid buffer captures C, then C, D follow with no loss or duplicate; `done` 3 cycles later than the no-stall case.
- start_addr=254, end_addr=1 with ADDR_WIDTH=8: `mem_addr` sequence 254,255,0,1; exactly 4 instructions; `done` pulse.
- start_addr=end_addr=7: exactly one instruction SRAM[7]; `done` 1 cycle after its consume.
- `abort` with `stall` held mid-run: `code_valid`=0 and `code`=NOP_CODE the next cycle; no `done`; a subsequent `start` 0→1 runs cleanly. A second `start` during a run is ignored.
- `reset_n` pulsed low mid-run asynchronously: all outputs return to reset values immediately; no `done`.
